// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_adder.sv
// Combinational 1-bit full-adder cell, mirror of the full-subtractor cell.
module full_adder (
   input  logic A,
   input  logic B,
   input  logic Ci,
   output logic S,
   output logic Co
);

   assign S  = A ^ B ^ Ci;
   assign Co = (A & B) | (A & Ci) | (B & Ci);

endmodule

// File: rtl/serial_adder.sv
// LSB-first bit-serial adder: {co, sum} = a + b + ci, one bit per clock,
// with valid/ready handshakes on operands and result.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             co
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic [WIDTH-1:0] sum_sr_nxt;
   logic             c;
   logic             s;
   logic             c_nxt;
   logic [CW-1:0]    cnt;
   logic             last;

   full_adder u_fa (
      .A  (a_sr[0]),
      .B  (b_sr[0]),
      .Ci (c),
      .S  (s),
      .Co (c_nxt)
   );

   // New bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
   assign sum_sr_nxt = (sum_sr >> 1) | (WIDTH'(s) << (WIDTH - 1));
   assign last       = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = BUSY;
         BUSY:    if (last)     state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // Datapath: capture in IDLE, shift in BUSY, result registers load only on the final bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         c      <= 1'b0;
         cnt    <= '0;
         sum    <= '0;
         co     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sr <= a;
                  b_sr <= b;
                  c    <= ci;
                  cnt  <= '0;
               end
            end
            BUSY: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               c      <= c_nxt;
               sum_sr <= sum_sr_nxt;
               cnt    <= cnt + CW'(1);
               if (last) begin
                  sum <= sum_sr_nxt;
                  co  <= c_nxt;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH 8 and WIDTH 1 against an arithmetic model.
module tb_serial_adder;

   logic       clk;
   logic       rst_n;

   logic       in_valid8, in_ready8, ci8, out_valid8, out_ready8, co8;
   logic [7:0] a8, b8, sum8;

   logic       in_valid1, in_ready1, ci1, out_valid1, out_ready1, co1;
   logic [0:0] a1, b1, sum1;

   int n_vec;
   int n_err;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .ci(ci8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .sum(sum8), .co(co8)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .ci(ci1),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .sum(sum1), .co(co1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present operands for one edge on the WIDTH-8 instance.
   task automatic accept8(input logic [7:0] a, input logic [7:0] b, input logic ci);
      a8 = a; b8 = b; ci8 = ci; in_valid8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
   endtask

   // Count edges until out_valid, bounded; also flags in_ready while busy.
   task automatic wait_done8(input string tag, output int lat);
      int bad_ready;
      lat = 0;
      bad_ready = 0;
      while (!out_valid8 && lat < 40) begin
         tick();
         lat++;
         if (in_ready8) bad_ready++;
      end
      chk({tag, "_ready_low"}, 32'(bad_ready), 32'd0);
      chk({tag, "_latency"}, 32'(lat), 32'd8);
   endtask

   // Full transaction with model check and an optional result stall.
   task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input int stall);
      int lat;
      int unsigned r;
      r = 32'(a) + 32'(b) + 32'(ci);
      out_ready8 = (stall == 0);
      accept8(a, b, ci);
      wait_done8(tag, lat);
      chk({tag, "_sum"}, 32'(sum8), r & 32'hFF);
      chk({tag, "_co"},  32'(co8),  (r >> 8) & 32'h1);
      for (int i = 0; i < stall; i++) begin
         tick();
         chk({tag, "_stall_valid"}, 32'(out_valid8), 32'd1);
         chk({tag, "_stall_sum"},   32'(sum8), r & 32'hFF);
         chk({tag, "_stall_co"},    32'(co8),  (r >> 8) & 32'h1);
      end
      out_ready8 = 1'b1;
      tick();
      chk({tag, "_post_valid"}, 32'(out_valid8), 32'd0);
      chk({tag, "_post_ready"}, 32'(in_ready8),  32'd1);
   endtask

   task automatic run1(input string tag, input logic a, input logic b, input logic ci);
      int lat;
      int unsigned r;
      r = 32'(a) + 32'(b) + 32'(ci);
      a1 = a; b1 = b; ci1 = ci; in_valid1 = 1'b1; out_ready1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      lat = 0;
      while (!out_valid1 && lat < 10) begin
         tick();
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'd1);
      chk({tag, "_sum"}, 32'(sum1), r & 32'h1);
      chk({tag, "_co"},  32'(co1),  (r >> 1) & 32'h1);
      tick();
      chk({tag, "_post_ready"}, 32'(in_ready1), 32'd1);
   endtask

   initial begin
      int lat;
      int seen;
      n_vec = 0; n_err = 0;
      clk = 1'b0; rst_n = 1'b0;
      in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; ci8 = 1'b0;
      in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0; ci1 = 1'b0;
      tick(); tick();
      chk("rst_in_ready",  32'(in_ready8),  32'd1);
      chk("rst_out_valid", 32'(out_valid8), 32'd0);
      chk("rst_sum",       32'(sum8),       32'd0);
      chk("rst_co",        32'(co8),        32'd0);
      chk("rst1_in_ready", 32'(in_ready1),  32'd1);
      rst_n = 1'b1;
      tick();

      run8("t1", 8'h5A, 8'h33, 1'b0, 0);
      run8("t2a", 8'hFF, 8'h01, 1'b0, 0);
      run8("t2b", 8'hFF, 8'hFF, 1'b1, 0);
      run8("t3", 8'h10, 8'h20, 1'b1, 5);

      // Operands offered during BUSY must wait for the return to IDLE.
      out_ready8 = 1'b1;
      accept8(8'h01, 8'h01, 1'b0);
      a8 = 8'hAA; b8 = 8'h55; ci8 = 1'b0; in_valid8 = 1'b1;
      wait_done8("t4a", lat);
      chk("t4a_sum", 32'(sum8), 32'h02);
      chk("t4a_co",  32'(co8),  32'h0);
      tick();
      chk("t4_idle_ready", 32'(in_ready8), 32'd1);
      tick();
      in_valid8 = 1'b0;
      wait_done8("t4b", lat);
      chk("t4b_sum", 32'(sum8), 32'hFF);
      chk("t4b_co",  32'(co8),  32'h0);
      tick();

      // Reset on the third BUSY cycle discards the operation.
      accept8(8'h77, 8'h66, 1'b1);
      tick(); tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("t5_in_ready",  32'(in_ready8),  32'd1);
      chk("t5_out_valid", 32'(out_valid8), 32'd0);
      chk("t5_sum",       32'(sum8),       32'd0);
      chk("t5_co",        32'(co8),        32'd0);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (out_valid8) seen++;
      end
      chk("t5_no_valid", 32'(seen), 32'd0);

      run1("t6a", 1'b1, 1'b1, 1'b0);
      run1("t6b", 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 8; k++) begin
         logic [2:0] v;
         v = 3'(k);
         run1("w1_all", v[2], v[1], v[0]);
      end

      for (int k = 0; k < 24; k++) begin
         run8("rnd", 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
